tmc4671_spi_responder: RTL and testbench

- SPI slave that emulates the TMC4671 register interface. It lets the Avalon-side SPI master and its driver software run against an in-fabric model for loopback, bring-up and hardware-in-the-loop tests.
- Decodes 40-bit datagrams (R/W bit, 7-bit address, 32-bit data) in SPI mode 3 and holds a 128x32 register file.
- Reports every SPI write to the fabric and accepts host-side presets, so a test harness can both feed and observe the emulated chip.

---
 rtl/tmc4671_spi_responder.sv | 172 +++++++++++++++++
 tb/tb_tmc4671_spi_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tmc4671_spi_responder.sv
// SPI mode-3 slave emulating the TMC4671 40-bit register datagram interface.
// It holds a 128x32 register file, reports SPI writes and accepts host presets.
module tmc4671_spi_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nSCS,
  input  logic        SCK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        miso_oe,
  output logic        wr_strobe,
  output logic [6:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        rd_strobe,
  input  logic        host_we,
  input  logic [6:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        frame_error
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, nscs_sync, mosi_sync;
  logic        sck_q, nscs_q;
  logic        sck_s, nscs_s, mosi_s;
  logic        sck_rise, sck_fall, nscs_fall, nscs_rise;

  logic [31:0] regs [128];
  logic [5:0]  bit_cnt;
  logic [7:0]  cmd_sr;
  logic [7:0]  cmd_nxt;
  logic [31:0] rx_sr, tx_sr;
  logic [31:0] rd_word;
  logic        rw, overrun, miso_q;
  logic [6:0]  addr;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign nscs_s = nscs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // SCK edges only count while the synced chip select is active.
  assign sck_rise  =  sck_s & ~sck_q & ~nscs_s;
  assign sck_fall  = ~sck_s &  sck_q & ~nscs_s;
  assign nscs_fall = ~nscs_s &  nscs_q;
  assign nscs_rise =  nscs_s & ~nscs_q;

  assign cmd_nxt = {cmd_sr[6:0], mosi_s};
  assign rd_word = regs[cmd_nxt[6:0]];
  assign MISO    = miso_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '1;
      nscs_sync <= '1;
      mosi_sync <= '0;
      sck_q     <= 1'b1;
      nscs_q    <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      nscs_sync <= {nscs_sync[SYNC_STAGES-2:0], nSCS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sck_q     <= sck_s;
      nscs_q    <= nscs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (nscs_fall) state_nxt = CMD;
      CMD: begin
        if (nscs_rise)                           state_nxt = IDLE;
        else if (sck_rise && bit_cnt == 6'd7)    state_nxt = DATA;
      end
      DATA: begin
        if (nscs_rise)                           state_nxt = IDLE;
        else if (sck_rise && bit_cnt == 6'd39)   state_nxt = DONE;
      end
      DONE: if (nscs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) regs[i] <= RESET_VALUE;
      bit_cnt     <= '0;
      cmd_sr      <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      rw          <= 1'b0;
      addr        <= '0;
      overrun     <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe     <= 1'b0;
      wr_strobe   <= 1'b0;
      rd_strobe   <= 1'b0;
      frame_error <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      wr_strobe   <= 1'b0;
      rd_strobe   <= 1'b0;
      frame_error <= 1'b0;
      if (host_we) regs[host_addr] <= host_wdata;

      case (state)
        IDLE: if (nscs_fall) begin
          bit_cnt <= '0;
          cmd_sr  <= '0;
          rx_sr   <= '0;
          overrun <= 1'b0;
          miso_oe <= 1'b1;
          miso_q  <= 1'b0;
        end
        CMD: if (sck_rise) begin
          cmd_sr  <= cmd_nxt;
          bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt == 6'd7) begin
            rw     <= cmd_nxt[7];
            addr   <= cmd_nxt[6:0];
            tx_sr  <= rd_word;
            miso_q <= rd_word[31];
          end
        end
        DATA: begin
          if (sck_rise) begin
            rx_sr   <= {rx_sr[30:0], mosi_s};
            bit_cnt <= bit_cnt + 6'd1;
          end
          // MISO already shows bit 31 after the load, so present-then-shift
          // keeps the master's first data sample on bit 31.
          if (sck_fall) begin
            miso_q <= tx_sr[31];
            tx_sr  <= {tx_sr[30:0], 1'b0};
          end
        end
        DONE: if (sck_rise) overrun <= 1'b1;
        default: ;
      endcase

      // Placed after the host preset so an SPI commit wins on collision.
      if (state != IDLE && nscs_rise) begin
        miso_oe <= 1'b0;
        miso_q  <= 1'b0;
        if (bit_cnt == 6'd40 && !overrun) begin
          if (rw) begin
            regs[addr] <= rx_sr;
            wr_strobe  <= 1'b1;
            wr_addr    <= addr;
            wr_data    <= rx_sr;
          end else begin
            rd_strobe  <= 1'b1;
          end
        end else begin
          frame_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tmc4671_spi_responder.sv
// Directed bench for tmc4671_spi_responder: acts as SPI master and host.
module tb_tmc4671_spi_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        nSCS, SCK, MOSI;
  logic        MISO, miso_oe;
  logic        wr_strobe, rd_strobe, frame_error;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        host_we;
  logic [6:0]  host_addr;
  logic [31:0] host_wdata;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0, rd_cnt = 0, fe_cnt = 0, act_cnt = 0;

  always #5 clk = ~clk;

  tmc4671_spi_responder #(.SYNC_STAGES(2), .RESET_VALUE(32'h0)) dut (
    .clk(clk), .reset(reset), .nSCS(nSCS), .SCK(SCK), .MOSI(MOSI),
    .MISO(MISO), .miso_oe(miso_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_strobe(rd_strobe), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .frame_error(frame_error)
  );

  always @(negedge clk) begin
    if (wr_strobe)   wr_cnt++;
    if (rd_strobe)   rd_cnt++;
    if (frame_error) fe_cnt++;
    if (wr_strobe || rd_strobe || frame_error || miso_oe || MISO) act_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clocks nbits SCK cycles with nSCS held low; returns MISO bits 31..0.
  task automatic spi_xfer(input logic [7:0] cmd, input logic [31:0] data,
                          input int nbits, output logic [31:0] word);
    logic [39:0] dg;
    dg   = {cmd, data};
    word = '0;
    nSCS = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      SCK  = 1'b0;
      MOSI = (i < 40) ? dg[39-i] : 1'b0;
      tick(4);
      if (i >= 8 && i < 40) word[39-i] = MISO;
      if (i == 0) chk("miso_oe_active", {31'd0, miso_oe}, 32'd1);
      SCK = 1'b1;
      tick(4);
    end
  endtask

  task automatic cs_release();
    tick(4);
    nSCS = 1'b1;
    MOSI = 1'b0;
    tick(8);
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] data,
                           input int nbits, output logic [31:0] word);
    spi_xfer(cmd, data, nbits, word);
    cs_release();
  endtask

  task automatic host_write(input logic [6:0] a, input logic [31:0] d);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    tick(1);
    host_we    = 1'b0;
  endtask

  logic [31:0] w;
  int wr0, rd0, fe0, act0;

  initial begin
    reset = 1'b1; nSCS = 1'b1; SCK = 1'b1; MOSI = 1'b0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    tick(3);
    chk("rst_miso",    {31'd0, MISO},        32'd0);
    chk("rst_miso_oe", {31'd0, miso_oe},     32'd0);
    chk("rst_wr_strb", {31'd0, wr_strobe},   32'd0);
    chk("rst_rd_strb", {31'd0, rd_strobe},   32'd0);
    chk("rst_fe",      {31'd0, frame_error}, 32'd0);
    chk("rst_wr_addr", {25'd0, wr_addr},     32'd0);
    chk("rst_wr_data", wr_data,              32'd0);
    reset = 1'b0;
    tick(4);

    // Host preset then read.
    host_write(7'h01, 32'h0034_0001);
    wr0 = wr_cnt; rd0 = rd_cnt;
    spi_frame(8'h01, 32'h0, 40, w);
    chk("rd1_data",  w,             32'h0034_0001);
    chk("rd1_rdcnt", rd_cnt - rd0,  32'd1);
    chk("rd1_wrcnt", wr_cnt - wr0,  32'd0);
    chk("idle_oe",   {31'd0, miso_oe}, 32'd0);

    // Write; MISO returns the old contents.
    wr0 = wr_cnt;
    spi_frame(8'h81, 32'hDEAD_BEEF, 40, w);
    chk("wr1_old",   w,             32'h0034_0001);
    chk("wr1_cnt",   wr_cnt - wr0,  32'd1);
    chk("wr1_addr",  {25'd0, wr_addr}, 32'h01);
    chk("wr1_data",  wr_data,       32'hDEAD_BEEF);
    spi_frame(8'h01, 32'h0, 40, w);
    chk("rd2_data",  w,             32'hDEAD_BEEF);

    // Short frame.
    wr0 = wr_cnt; fe0 = fe_cnt;
    spi_frame(8'h85, 32'h1234_5678, 20, w);
    chk("short_fe",  fe_cnt - fe0,  32'd1);
    chk("short_wr",  wr_cnt - wr0,  32'd0);
    chk("hold_addr", {25'd0, wr_addr}, 32'h01);
    spi_frame(8'h05, 32'h0, 40, w);
    chk("short_rd",  w,             32'h0);

    // Overrun frame, then a good frame right after.
    wr0 = wr_cnt; fe0 = fe_cnt;
    spi_frame(8'h82, 32'hAAAA_5555, 41, w);
    chk("ovr_fe",    fe_cnt - fe0,  32'd1);
    chk("ovr_wr",    wr_cnt - wr0,  32'd0);
    spi_frame(8'h02, 32'h0, 40, w);
    chk("ovr_rd",    w,             32'h0);
    fe0 = fe_cnt; wr0 = wr_cnt;
    spi_frame(8'h82, 32'h0BAD_F00D, 40, w);
    chk("after_wr",  wr_cnt - wr0,  32'd1);
    chk("after_fe",  fe_cnt - fe0,  32'd0);
    spi_frame(8'h02, 32'h0, 40, w);
    chk("after_rd",  w,             32'h0BAD_F00D);

    // Host preset colliding with the SPI commit clk edge.
    spi_xfer(8'h83, 32'h2222_2222, 40, w);
    tick(4);
    nSCS = 1'b1;
    tick(2);
    host_addr = 7'h03; host_wdata = 32'h1111_1111; host_we = 1'b1;
    tick(1);
    host_we = 1'b0;
    chk("coll_strobe", {31'd0, wr_strobe}, 32'd1);
    tick(6);
    spi_frame(8'h03, 32'h0, 40, w);
    chk("coll_rd",   w,             32'h2222_2222);

    // Reset mid-frame.
    wr0 = wr_cnt; fe0 = fe_cnt;
    spi_xfer(8'h84, 32'hCAFE_F00D, 25, w);
    reset = 1'b1;
    tick(2);
    chk("mid_rst_oe", {31'd0, miso_oe}, 32'd0);
    nSCS = 1'b1; SCK = 1'b1; MOSI = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(8);
    chk("mid_rst_wr", wr_cnt - wr0, 32'd0);
    chk("mid_rst_fe", fe_cnt - fe0, 32'd0);
    spi_frame(8'h04, 32'h0, 40, w);
    chk("mid_rst_rd", w,            32'h0);

    // SCK activity with chip select high.
    act0 = act_cnt;
    for (int i = 0; i < 10; i++) begin
      SCK = 1'b0; MOSI = i[0]; tick(4);
      SCK = 1'b1; tick(4);
    end
    tick(6);
    chk("cs_high_act", act_cnt - act0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
